mash_noise_cancel: RTL



---
 rtl/mash_pkg.sv | 18 +
 rtl/mash_diff_stage.sv | 24 ++
 rtl/mash_noise_cancel.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mash_pkg.sv
// rtl/mash_pkg.sv - shared constants and helpers for the MASH 1-1-1 noise canceller
package mash_pkg;

  localparam int MASH_STAGES = 3;

  localparam logic [1:0] ORD_1 = 2'd1;
  localparam logic [1:0] ORD_2 = 2'd2;
  localparam logic [1:0] ORD_3 = 2'd3;

  localparam int MASH_OUT_MIN = -3;
  localparam int MASH_OUT_MAX = 4;

  // Enabled cycles until every alignment and history register holds real data.
  function automatic int fill_count(input int stage_lat);
    return 2 * stage_lat + 3;
  endfunction

endpackage

// File: rtl/mash_diff_stage.sv
// rtl/mash_diff_stage.sv - enabled first-difference y = x - x_z1
module mash_diff_stage #(
  parameter int P_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic signed [P_WIDTH-1:0] x,
  output logic signed [P_WIDTH-1:0] y
);

  logic signed [P_WIDTH-1:0] x_z1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_z1 <= '0;
    end else if (en) begin
      x_z1 <= x;
    end
  end

  assign y = x - x_z1;

endmodule

// File: rtl/mash_noise_cancel.sv
// rtl/mash_noise_cancel.sv - MASH 1-1-1 recombiner: skew alignment, differentiators, output register
// Optional divider-word output is built when macro NCL_DIV_OUT_EN is defined.
module mash_noise_cancel
  import mash_pkg::*;
#(
  parameter int P_STAGE_LAT = 1,
  parameter int P_OUT_WIDTH = 4,
  parameter int P_INT_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic [1:0]             i_order_sel,
  input  logic [MASH_STAGES-1:0] i_cout,
  output logic [P_OUT_WIDTH-1:0] o_mash_out,
  output logic                   o_valid
`ifdef NCL_DIV_OUT_EN
  ,
  input  logic [P_INT_WIDTH-1:0] i_n_int,
  output logic [P_INT_WIDTH-1:0] o_div
`endif
);

  localparam int FILL = fill_count(P_STAGE_LAT);
  localparam int CW   = $clog2(FILL + 1);

  if (P_OUT_WIDTH < 4 || MASH_OUT_MAX >= (1 << (P_OUT_WIDTH - 1)) ||
      MASH_OUT_MIN < -(1 << (P_OUT_WIDTH - 1)) || P_INT_WIDTH < P_OUT_WIDTH ||
      P_STAGE_LAT < 0 || P_STAGE_LAT > 4) begin : g_bad_param
    $error("mash_noise_cancel: parameter out of supported range");
  end

  logic                          c1a;
  logic                          c2a;
  logic signed [P_OUT_WIDTH-1:0] c1x;
  logic signed [P_OUT_WIDTH-1:0] c2x;
  logic signed [P_OUT_WIDTH-1:0] c3x;
  logic signed [P_OUT_WIDTH-1:0] d2;
  logic signed [P_OUT_WIDTH-1:0] d3_first;
  logic signed [P_OUT_WIDTH-1:0] d3;
  logic signed [P_OUT_WIDTH-1:0] sum;
  logic [CW-1:0]                 fill_cnt;
  logic [CW-1:0]                 fill_adv;

  // Earlier stages carry more pipeline skew, so they are delayed to line up with stage 3.
  if (P_STAGE_LAT == 0) begin : g_no_delay
    assign c1a = i_cout[0];
    assign c2a = i_cout[1];
  end else begin : g_delay
    logic [2*P_STAGE_LAT-1:0] c1_sr;
    logic [P_STAGE_LAT-1:0]   c2_sr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        c1_sr <= '0;
        c2_sr <= '0;
      end else if (i_en) begin
        c1_sr[0] <= i_cout[0];
        for (int k = 1; k < 2 * P_STAGE_LAT; k++) c1_sr[k] <= c1_sr[k-1];
        c2_sr[0] <= i_cout[1];
        for (int k = 1; k < P_STAGE_LAT; k++) c2_sr[k] <= c2_sr[k-1];
      end
    end

    assign c1a = c1_sr[2*P_STAGE_LAT-1];
    assign c2a = c2_sr[P_STAGE_LAT-1];
  end

  assign c1x = {{(P_OUT_WIDTH-1){1'b0}}, c1a};
  assign c2x = {{(P_OUT_WIDTH-1){1'b0}}, c2a};
  assign c3x = {{(P_OUT_WIDTH-1){1'b0}}, i_cout[2]};

  mash_diff_stage #(.P_WIDTH(P_OUT_WIDTH)) u_diff_c2 (
    .clk(i_clk), .rst_n(i_rst_n), .en(i_en), .x(c2x), .y(d2)
  );

  // Two cascaded first differences give c3 - 2*c3_z1 + c3_z2.
  mash_diff_stage #(.P_WIDTH(P_OUT_WIDTH)) u_diff_c3a (
    .clk(i_clk), .rst_n(i_rst_n), .en(i_en), .x(c3x), .y(d3_first)
  );

  mash_diff_stage #(.P_WIDTH(P_OUT_WIDTH)) u_diff_c3b (
    .clk(i_clk), .rst_n(i_rst_n), .en(i_en), .x(d3_first), .y(d3)
  );

  always_comb begin
    sum = c1x;
    case (i_order_sel)
      ORD_1:        sum = c1x;
      ORD_2:        sum = c1x + d2;
      ORD_3, 2'd0:  sum = c1x + d2 + d3;
    endcase
  end

  assign fill_adv = (fill_cnt == CW'(FILL)) ? fill_cnt : fill_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fill_cnt   <= '0;
      o_mash_out <= '0;
      o_valid    <= 1'b0;
    end else begin
      o_valid <= i_en && (fill_adv == CW'(FILL));
      if (i_en) begin
        fill_cnt   <= fill_adv;
        o_mash_out <= sum;
      end
    end
  end

`ifdef NCL_DIV_OUT_EN
  logic signed [P_INT_WIDTH-1:0] sum_ext;

  assign sum_ext = P_INT_WIDTH'(sum);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_div <= '0;
    end else if (i_en) begin
      o_div <= i_n_int + sum_ext;
    end
  end
`endif

endmodule
